// File: rtl/hb_beat_stream_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hb_beat_stream_ctrl
//  Description : Heartbeat sample buffer controller. Writes ADC samples into
//                a single-port RAM (writer has priority) and, on each
//                accepted heartbeat, streams the just-completed beat out over
//                a valid/ready interface.
//  Revision    : 1.0 - initial release
// ============================================================================
module hb_beat_stream_ctrl #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 12,
  parameter int MIN_BEAT = 100,
  parameter int MAX_BEAT = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_i,
  input  logic [DATA_W-1:0] sample_data_i,
  input  logic              heartbeat_detect_i,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  input  logic              out_ready_i,
  output logic [ADDR_W-1:0] beat_len_o,
  output logic              busy_o,
  output logic              overrun_o
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_PRESENT = 2'd3;

  // MAX_BEAT <= 2^(ADDR_W-1), so MAX_BEAT+1 (the saturation value) fits in ADDR_W bits
  localparam logic [ADDR_W-1:0] c_one     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] c_min     = ADDR_W'(MIN_BEAT);
  localparam logic [ADDR_W-1:0] c_max     = ADDR_W'(MAX_BEAT);
  localparam logic [ADDR_W-1:0] c_sat     = ADDR_W'(MAX_BEAT + 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] beat_start_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              armed_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W-1:0] remaining_q;
  logic [ADDR_W-1:0] beat_len_q;
  logic [DATA_W-1:0] out_data_q;
  logic              out_valid_q;
  logic              out_last_q;
  logic              overrun_q;

  logic w_busy;
  logic w_ignore;
  logic w_restart;
  logic w_too_long;
  logic w_overrun;
  logic w_accept;

  // Heartbeat classification; cnt_q is the beat length before any same-cycle sample
  assign w_busy     = (state_q != S_IDLE);
  assign w_ignore   = heartbeat_detect_i & armed_q & (cnt_q < c_min);
  assign w_restart  = heartbeat_detect_i & ~w_ignore;
  assign w_too_long = cnt_q > c_max;
  assign w_overrun  = w_restart & armed_q & (w_too_long | w_busy);
  assign w_accept   = w_restart & armed_q & ~w_too_long & ~w_busy;

  // FSM state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state: ISSUE waits while the writer owns the RAM port
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (w_accept) state_d = S_ISSUE;
      S_ISSUE:   if (!sample_i) state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_PRESENT;
      S_PRESENT: if (out_ready_i) state_d = out_last_q ? S_IDLE : S_ISSUE;
      default:   state_d = S_IDLE;
    endcase
  end

  // RAM port control: sample write wins, otherwise the readout may read
  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (!reset) begin
      if (sample_i) begin
        ram_en_o    = 1'b1;
        ram_we_o    = 1'b1;
        ram_addr_o  = wr_ptr_q;
        ram_wdata_o = sample_data_i;
      end else if (state_q == S_ISSUE) begin
        ram_en_o   = 1'b1;
        ram_addr_o = rd_ptr_q;
      end
    end
  end

  // Writer pointer, beat bookkeeping and overrun pulse
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      beat_start_q <= '0;
      cnt_q        <= '0;
      armed_q      <= 1'b0;
      beat_len_q   <= '0;
      overrun_q    <= 1'b0;
    end else begin
      if (sample_i) wr_ptr_q <= wr_ptr_q + c_one;
      if (w_restart) begin
        // A coincident sample is the first sample of the new beat
        armed_q      <= 1'b1;
        beat_start_q <= wr_ptr_q;
        cnt_q        <= sample_i ? c_one : '0;
      end else if (sample_i && cnt_q != c_sat) begin
        cnt_q <= cnt_q + c_one;
      end
      if (w_accept) beat_len_q <= cnt_q;
      overrun_q <= w_overrun;
    end
  end

  // Readout datapath: read pointer, word countdown and output register
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q    <= '0;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_accept) begin
            rd_ptr_q    <= beat_start_q;
            remaining_q <= cnt_q;
          end
        end
        S_CAPTURE: begin
          out_data_q  <= ram_rdata_i;
          out_valid_q <= 1'b1;
          out_last_q  <= (remaining_q == c_one);
        end
        S_PRESENT: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            rd_ptr_q    <= rd_ptr_q + c_one;
            remaining_q <= remaining_q - c_one;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;
  assign beat_len_o  = beat_len_q;
  assign busy_o      = w_busy;
  assign overrun_o   = overrun_q;

endmodule
`default_nettype wire
